vscale_hpm_csr: RTL and testbench

Parametrised hardware-performance-monitor CSR block for the vscale core: NUM_CNT 64-bit event counters with per-counter event select, global inhibit, overflow status and an overflow interrupt. Sits beside the machine-mode CSR file on the same CSR read/write bus; the core routes addresses in its ranges here and ORs `illegal_access`/`rdata`. A host (HTIF-style) request/response port gives debug access to the same registers.

---
 rtl/vscale_hpm_pkg.sv | 32 +++
 rtl/vscale_hpm_counter.sv | 46 ++++
 rtl/vscale_hpm_csr.sv | 224 ++++++++++++++++++++++
 tb/tb_vscale_hpm_csr.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_hpm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vscale_hpm_pkg : address map, CSR command codes and host FSM states for     |
// |                  the vscale hardware-performance-monitor CSR block.         |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
package vscale_hpm_pkg;

  localparam logic [11:0] CSR_ADDR_MHPMCOUNTER   = 12'hB03;
  localparam logic [11:0] CSR_ADDR_MHPMCOUNTERH  = 12'hB83;
  localparam logic [11:0] CSR_ADDR_HPMCOUNTER    = 12'hC03;
  localparam logic [11:0] CSR_ADDR_HPMCOUNTERH   = 12'hC83;
  localparam logic [11:0] CSR_ADDR_MHPMEVENT     = 12'h323;
  localparam logic [11:0] CSR_ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_ADDR_HPMOVF        = 12'h7C0;
  localparam logic [11:0] CSR_ADDR_HPMOVFEN      = 12'h7C1;

  localparam logic [2:0] CSR_IDLE  = 3'd0;
  localparam logic [2:0] CSR_READ  = 3'd4;
  localparam logic [2:0] CSR_WRITE = 3'd5;
  localparam logic [2:0] CSR_SET   = 3'd6;
  localparam logic [2:0] CSR_CLEAR = 3'd7;

  localparam int EVSEL_W = 8;

  typedef enum logic [0:0] {
    HTIF_IDLE = 1'b0,
    HTIF_WAIT = 1'b1
  } htif_state_e;

endpackage
`default_nettype wire

// File: rtl/vscale_hpm_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vscale_hpm_counter : one event counter with independent 32-bit half writes, |
// |                      single-step increment and wrap detection.              |
// | Revision           : 1.0                                                    |
// +----------------------------------------------------------------------------+
module vscale_hpm_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 wrap
);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  // A half write replaces only that half and suppresses the increment.
  always_comb begin
    count_d = count_q;
    if (wr_lo) begin
      count_d[31:0] = wdata;
    end else if (wr_hi) begin
      count_d[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
    end else if (inc) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  assign wrap  = inc & ~wr_lo & ~wr_hi & (&count_q);
  assign count = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vscale_hpm_csr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vscale_hpm_csr : HPM counter CSRs with event select, inhibit, host port;    |
// |                  overflow status/irq when VSCALE_HPM_OVF_IRQ_EN is defined. |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module vscale_hpm_csr
  import vscale_hpm_pkg::*;
#(
  parameter int NUM_CNT    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [11:0]           addr,
  input  logic [2:0]            cmd,
  input  logic [31:0]           wdata,
  input  logic [1:0]            prv,
  output logic [31:0]           rdata,
  output logic                  illegal_access,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  hpm_irq,
  input  logic                  htif_req_valid,
  output logic                  htif_req_ready,
  input  logic                  htif_req_rw,
  input  logic [11:0]           htif_req_addr,
  input  logic [31:0]           htif_req_data,
  output logic                  htif_resp_valid,
  input  logic                  htif_resp_ready,
  output logic [31:0]           htif_resp_data
);

  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_CNT-1:0]                cnt_inc, cnt_wr_lo, cnt_wr_hi, cnt_wrap;
  logic [NUM_CNT-1:0][EVSEL_W-1:0]   evsel_q, evsel_d;
  logic [NUM_CNT-1:0]                inhibit_q, inhibit_d;
  htif_state_e                       state_q, state_d;
  logic [31:0]                       resp_data_q, resp_data_d;

  logic        sys_hit, host_hit, sys_wr_req, sys_wr, host_acc, host_wr, wr_en;
  logic [31:0] host_rdata, sys_wval, wr_val;
  logic [11:0] wr_addr;

`ifdef VSCALE_HPM_OVF_IRQ_EN
  logic [NUM_CNT-1:0] ovf_q, ovf_d, ovfen_q, ovfen_d;
  logic               irq_q, irq_d;
`endif

  // Returns {owned, value}; unowned addresses read as zero.
  function automatic logic [32:0] csr_read(input logic [11:0] a);
    logic        hit;
    logic [31:0] d;
    hit = 1'b0;
    d   = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (a == CSR_ADDR_MHPMCOUNTER + 12'(i) || a == CSR_ADDR_HPMCOUNTER + 12'(i)) begin
        hit = 1'b1;
        d   = cnt[i][31:0];
      end
      if (a == CSR_ADDR_MHPMCOUNTERH + 12'(i) || a == CSR_ADDR_HPMCOUNTERH + 12'(i)) begin
        hit = 1'b1;
        d   = 32'(cnt[i][CNT_WIDTH-1:32]);
      end
      if (a == CSR_ADDR_MHPMEVENT + 12'(i)) begin
        hit = 1'b1;
        d   = 32'(evsel_q[i]);
      end
    end
    if (a == CSR_ADDR_MCOUNTINHIBIT) begin
      hit = 1'b1;
      d   = 32'({inhibit_q, 3'b000});
    end
`ifdef VSCALE_HPM_OVF_IRQ_EN
    if (a == CSR_ADDR_HPMOVF) begin
      hit = 1'b1;
      d   = 32'(ovf_q);
    end
    if (a == CSR_ADDR_HPMOVFEN) begin
      hit = 1'b1;
      d   = 32'(ovfen_q);
    end
`endif
    return {hit, d};
  endfunction

  always_comb begin : read_decode
    {sys_hit, rdata}       = csr_read(addr);
    {host_hit, host_rdata} = csr_read(htif_req_addr);
  end

  // System and host writes never coincide: the host port stalls on any system write.
  always_comb begin : access_ctrl
    sys_wr_req     = cmd[2] & (cmd[1] | cmd[0]);
    illegal_access = cmd[2] & (~sys_hit | (sys_wr_req & (addr[11:10] == 2'b11)) | (addr[9:8] > prv));
    sys_wr         = sys_wr_req & ~illegal_access;
    sys_wval       = wdata;
    case (cmd)
      CSR_SET:   sys_wval = rdata | wdata;
      CSR_CLEAR: sys_wval = rdata & ~wdata;
      default:   sys_wval = wdata;
    endcase
    htif_req_ready = (state_q == HTIF_IDLE) & ~sys_wr_req;
    host_acc       = htif_req_valid & htif_req_ready;
    host_wr        = host_acc & htif_req_rw;
    wr_en          = sys_wr | host_wr;
    wr_addr        = sys_wr ? addr : htif_req_addr;
    wr_val         = sys_wr ? sys_wval : htif_req_data;
  end

  always_comb begin : cnt_ctrl
    logic ev_hit;
    evsel_d   = evsel_q;
    inhibit_d = inhibit_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_wr_lo[i] = wr_en & ((wr_addr == CSR_ADDR_MHPMCOUNTER + 12'(i)) |
                              (wr_addr == CSR_ADDR_HPMCOUNTER + 12'(i)));
      cnt_wr_hi[i] = wr_en & ((wr_addr == CSR_ADDR_MHPMCOUNTERH + 12'(i)) |
                              (wr_addr == CSR_ADDR_HPMCOUNTERH + 12'(i)));
      if (wr_en && wr_addr == CSR_ADDR_MHPMEVENT + 12'(i)) begin
        evsel_d[i] = wr_val[EVSEL_W-1:0];
      end
      ev_hit = 1'b0;
      for (int k = 1; k <= NUM_EVENTS; k++) begin
        if (evsel_q[i] == EVSEL_W'(k) && events[k-1]) begin
          ev_hit = 1'b1;
        end
      end
      cnt_inc[i] = ev_hit & ~inhibit_q[i];
    end
    if (wr_en && wr_addr == CSR_ADDR_MCOUNTINHIBIT) begin
      inhibit_d = wr_val[3 +: NUM_CNT];
    end
  end

  always_comb begin : host_fsm
    state_d     = state_q;
    resp_data_d = resp_data_q;
    case (state_q)
      HTIF_IDLE: begin
        if (host_acc) begin
          state_d     = HTIF_WAIT;
          resp_data_d = host_hit ? host_rdata : '0;
        end
      end
      HTIF_WAIT: begin
        if (htif_resp_ready) begin
          state_d = HTIF_IDLE;
        end
      end
      default: state_d = HTIF_IDLE;
    endcase
  end

  assign htif_resp_valid = (state_q == HTIF_WAIT);
  assign htif_resp_data  = resp_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HTIF_IDLE;
      resp_data_q <= '0;
      evsel_q     <= '0;
      inhibit_q   <= '0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      evsel_q     <= evsel_d;
      inhibit_q   <= inhibit_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      vscale_hpm_counter #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc[gi]),
        .wr_lo (cnt_wr_lo[gi]),
        .wr_hi (cnt_wr_hi[gi]),
        .wdata (wr_val),
        .count (cnt[gi]),
        .wrap  (cnt_wrap[gi])
      );
    end
  endgenerate

`ifdef VSCALE_HPM_OVF_IRQ_EN
  // A wrap in the same cycle as a software clear leaves the status bit set.
  always_comb begin : ovf_ctrl
    ovf_d   = ovf_q;
    ovfen_d = ovfen_q;
    if (wr_en && wr_addr == CSR_ADDR_HPMOVF) begin
      ovf_d = wr_val[NUM_CNT-1:0];
    end
    if (wr_en && wr_addr == CSR_ADDR_HPMOVFEN) begin
      ovfen_d = wr_val[NUM_CNT-1:0];
    end
    ovf_d = ovf_d | cnt_wrap;
    irq_d = |(ovf_q & ovfen_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= '0;
      ovfen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      ovfen_q <= ovfen_d;
      irq_q   <= irq_d;
    end
  end

  assign hpm_irq = irq_q;
`else
  logic unused_wrap;
  assign unused_wrap = ^cnt_wrap;
  assign hpm_irq     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vscale_hpm_csr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vscale_hpm_csr : vector table, directed corner sequences and random      |
// |                     traffic against a behavioural model of the HPM block.   |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_vscale_hpm_csr;

`ifdef VSCALE_HPM_OVF_IRQ_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] addr;
  logic [2:0]  cmd;
  logic [31:0] wdata;
  logic [1:0]  prv;
  logic [31:0] rdata;
  logic        illegal_access;
  logic [7:0]  events;
  logic        hpm_irq;
  logic        htif_req_valid, htif_req_ready, htif_req_rw;
  logic [11:0] htif_req_addr;
  logic [31:0] htif_req_data;
  logic        htif_resp_valid, htif_resp_ready;
  logic [31:0] htif_resp_data;

  vscale_hpm_csr #(.NUM_CNT(4), .CNT_WIDTH(64), .NUM_EVENTS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .addr            (addr),
    .cmd             (cmd),
    .wdata           (wdata),
    .prv             (prv),
    .rdata           (rdata),
    .illegal_access  (illegal_access),
    .events          (events),
    .hpm_irq         (hpm_irq),
    .htif_req_valid  (htif_req_valid),
    .htif_req_ready  (htif_req_ready),
    .htif_req_rw     (htif_req_rw),
    .htif_req_addr   (htif_req_addr),
    .htif_req_data   (htif_req_data),
    .htif_resp_valid (htif_resp_valid),
    .htif_resp_ready (htif_resp_ready),
    .htif_resp_data  (htif_resp_data)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit [63:0] m_cnt [4];
  bit [7:0]  m_sel [4];
  bit [3:0]  m_inh, m_ovf, m_ovfen;
  bit        m_irq, m_wait;
  bit [31:0] m_resp;

  typedef struct {
    bit [2:0]  cmd;
    bit [11:0] addr;
    bit [31:0] wd;
    bit [1:0]  prv;
    bit [31:0] exp_rd;
    bit        exp_ill;
  } vec_t;

  vec_t      vt [19];
  bit [11:0] alist [20];
  bit [2:0]  cmds [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  // {owned, value} as seen from the register map
  function automatic bit [32:0] m_read(input bit [11:0] a);
    for (int i = 0; i < 4; i++) begin
      if (int'(a) == 'hB03 + i || int'(a) == 'hC03 + i) return {1'b1, m_cnt[i][31:0]};
      if (int'(a) == 'hB83 + i || int'(a) == 'hC83 + i) return {1'b1, m_cnt[i][63:32]};
      if (int'(a) == 'h323 + i) return {1'b1, 24'b0, m_sel[i]};
    end
    if (a == 12'h320) return {1'b1, 25'b0, m_inh, 3'b000};
    if (OVF && a == 12'h7C0) return {1'b1, 28'b0, m_ovf};
    if (OVF && a == 12'h7C1) return {1'b1, 28'b0, m_ovfen};
    return 33'b0;
  endfunction

  function automatic bit m_illegal(input bit [11:0] a, input bit [2:0] c, input bit [1:0] p);
    bit [32:0] r;
    r = m_read(a);
    return c[2] && (!r[32] || ((c[1] || c[0]) && a[11:10] == 2'b11) || a[9:8] > p);
  endfunction

  // Advance the model by one cycle using the current inputs, then clock.
  task automatic step();
    bit [32:0] r, hr;
    bit [31:0] wv;
    bit [11:0] wa;
    bit        dow, sysw, acc, inc;
    bit [3:0]  wrap;
    int        s;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0;
        m_sel[i] = 0;
      end
      m_inh = 0; m_ovf = 0; m_ovfen = 0; m_irq = 0; m_wait = 0; m_resp = 0;
    end else begin
      r    = m_read(addr);
      sysw = cmd[2] && (cmd[1] || cmd[0]);
      acc  = !m_wait && htif_req_valid && !sysw;
      dow  = 0; wa = 0; wv = 0; wrap = 0;
      if (sysw && !m_illegal(addr, cmd, prv)) begin
        dow = 1; wa = addr;
        case (cmd)
          3'd6:    wv = r[31:0] | wdata;
          3'd7:    wv = r[31:0] & ~wdata;
          default: wv = wdata;
        endcase
      end else if (acc && htif_req_rw) begin
        dow = 1; wa = htif_req_addr; wv = htif_req_data;
      end
      m_irq = OVF && ((m_ovf & m_ovfen) != 0);
      if (acc) begin
        hr = m_read(htif_req_addr);
        m_resp = hr[31:0];
        m_wait = 1;
      end else if (m_wait && htif_resp_ready) begin
        m_wait = 0;
      end
      for (int i = 0; i < 4; i++) begin
        s   = int'(m_sel[i]);
        inc = !m_inh[i] && s >= 1 && s <= 8 && events[s-1];
        if (dow && (int'(wa) == 'hB03 + i || int'(wa) == 'hC03 + i)) m_cnt[i][31:0] = wv;
        else if (dow && (int'(wa) == 'hB83 + i || int'(wa) == 'hC83 + i)) m_cnt[i][63:32] = wv;
        else if (inc) begin
          if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) wrap[i] = 1;
          m_cnt[i] = m_cnt[i] + 64'd1;
        end
        if (dow && int'(wa) == 'h323 + i) m_sel[i] = wv[7:0];
      end
      if (dow && wa == 12'h320) m_inh = wv[6:3];
      if (OVF && dow && wa == 12'h7C0) m_ovf = wv[3:0];
      if (OVF && dow && wa == 12'h7C1) m_ovfen = wv[3:0];
      if (OVF) m_ovf = m_ovf | wrap;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic csr(input bit [2:0] c, input bit [11:0] a, input bit [31:0] d);
    cmd = c; addr = a; wdata = d; prv = 2'd3;
  endtask

  task automatic check_all();
    bit [32:0] r;
    r = m_read(addr);
    check("rnd_rdata", rdata, r[31:0]);
    check("rnd_illegal", 32'(illegal_access), 32'(m_illegal(addr, cmd, prv)));
    check("rnd_req_ready", 32'(htif_req_ready), 32'(!m_wait && !(cmd[2] && (cmd[1] || cmd[0]))));
    check("rnd_resp_valid", 32'(htif_resp_valid), 32'(m_wait));
    check("rnd_resp_data", htif_resp_data, m_resp);
    check("rnd_irq", 32'(hpm_irq), 32'(m_irq));
  endtask

  initial begin
    reset = 1; addr = 0; cmd = 0; wdata = 0; prv = 3; events = 0;
    htif_req_valid = 0; htif_req_rw = 0; htif_req_addr = 0; htif_req_data = 0;
    htif_resp_ready = 0;

    vt[0]  = '{3'd4, 12'hB03, 32'h0,   2'd0 + 2'd3, 32'h0,  1'b0};
    vt[1]  = '{3'd4, 12'hB03, 32'h0,   2'd0, 32'h0,  1'b1};
    vt[2]  = '{3'd4, 12'hC03, 32'h0,   2'd0, 32'h0,  1'b0};
    vt[3]  = '{3'd5, 12'h323, 32'h1,   2'd3, 32'h0,  1'b0};
    vt[4]  = '{3'd4, 12'h323, 32'h0,   2'd3, 32'h1,  1'b0};
    vt[5]  = '{3'd6, 12'h320, 32'h10,  2'd3, 32'h0,  1'b0};
    vt[6]  = '{3'd4, 12'h320, 32'h0,   2'd3, 32'h10, 1'b0};
    vt[7]  = '{3'd7, 12'h320, 32'h10,  2'd3, 32'h10, 1'b0};
    vt[8]  = '{3'd4, 12'h320, 32'h0,   2'd3, 32'h0,  1'b0};
    vt[9]  = '{3'd5, 12'hC03, 32'h5,   2'd3, 32'h0,  1'b1};
    vt[10] = '{3'd4, 12'hC03, 32'h0,   2'd3, 32'h0,  1'b0};
    vt[11] = '{3'd4, 12'h7C0, 32'h0,   2'd3, 32'h0,  !OVF};
    vt[12] = '{3'd4, 12'h323, 32'h0,   2'd1, 32'h1,  1'b1};
    vt[13] = '{3'd4, 12'h400, 32'h0,   2'd3, 32'h0,  1'b1};
    vt[14] = '{3'd5, 12'h324, 32'h1FF, 2'd3, 32'h0,  1'b0};
    vt[15] = '{3'd4, 12'h324, 32'h0,   2'd3, 32'hFF, 1'b0};
    vt[16] = '{3'd4, 12'h327, 32'h0,   2'd3, 32'h0,  1'b1};
    vt[17] = '{3'd5, 12'h324, 32'h0,   2'd3, 32'hFF, 1'b0};
    vt[18] = '{3'd4, 12'hC83, 32'h0,   2'd0, 32'h0,  1'b0};

    alist = '{12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB83, 12'hB84, 12'hC03, 12'hC04,
              12'hC83, 12'hC86, 12'h323, 12'h324, 12'h325, 12'h326, 12'h320, 12'h7C0,
              12'h7C1, 12'h327, 12'hB07, 12'h000};
    cmds  = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd7};

    step(); step();
    reset = 0;
    #2;
    check("reset_irq", 32'(hpm_irq), 32'h0);
    check("reset_req_ready", 32'(htif_req_ready), 32'h1);
    check("reset_resp_valid", 32'(htif_resp_valid), 32'h0);
    check("reset_resp_data", htif_resp_data, 32'h0);

    for (int v = 0; v < 19; v++) begin
      cmd = vt[v].cmd; addr = vt[v].addr; wdata = vt[v].wd; prv = vt[v].prv;
      #2;
      check($sformatf("vec%0d_rdata", v), rdata, vt[v].exp_rd);
      check($sformatf("vec%0d_illegal", v), 32'(illegal_access), 32'(vt[v].exp_ill));
      step();
    end
    csr(3'd0, 12'h0, 0);

    // Ten event cycles, then inhibited pulses must not count
    for (int n = 0; n < 10; n++) begin events = 8'h01; step(); end
    events = 0; csr(3'd4, 12'hB03, 0); #2;
    check("count_10", rdata, 32'd10);
    csr(3'd6, 12'h320, 32'h8); step();
    csr(3'd0, 12'h0, 0);
    for (int n = 0; n < 5; n++) begin events = 8'h01; step(); end
    events = 0; csr(3'd4, 12'hB03, 0); #2;
    check("inhibited", rdata, 32'd10);
    csr(3'd7, 12'h320, 32'h8); step();

    // 64-bit wrap
    csr(3'd5, 12'h7C1, 32'h1); if (OVF) step();
    csr(3'd5, 12'hB83, 32'hFFFF_FFFF); step();
    csr(3'd5, 12'hB03, 32'hFFFF_FFFE); step();
    csr(3'd0, 12'h0, 0);
    events = 8'h01; step(); step();
    events = 0; csr(3'd4, 12'hB03, 0); #2;
    check("wrap_lo", rdata, 32'h0);
    addr = 12'hB83; #1;
    check("wrap_hi", rdata, 32'h0);
    check("irq_same_cycle", 32'(hpm_irq), 32'h0);
`ifdef VSCALE_HPM_OVF_IRQ_EN
    addr = 12'h7C0; #1;
    check("hpmovf", rdata, 32'h1);
`endif
    step(); #1;
    check("irq_after_wrap", 32'(hpm_irq), 32'(OVF));
`ifdef VSCALE_HPM_OVF_IRQ_EN
    csr(3'd5, 12'h7C1, 32'h0); step();
    csr(3'd5, 12'h7C0, 32'h0); step();
`endif

    // Write beats a simultaneous event
    csr(3'd5, 12'hB03, 32'h1234); events = 8'h01; step();
    events = 0; csr(3'd4, 12'hB03, 0); #2;
    check("write_beats_inc", rdata, 32'h1234);

    // Host read held with back-pressure
    csr(3'd5, 12'hB04, 32'hABCD); step();
    csr(3'd0, 12'h0, 0);
    htif_req_valid = 1; htif_req_rw = 0; htif_req_addr = 12'hB04; htif_resp_ready = 0; #2;
    check("host_req_ready", 32'(htif_req_ready), 32'h1);
    step();
    htif_req_valid = 0;
    for (int n = 0; n < 3; n++) begin
      #2;
      check("host_hold_valid", 32'(htif_resp_valid), 32'h1);
      check("host_hold_data", htif_resp_data, 32'hABCD);
      step();
    end
    htif_resp_ready = 1; step();
    htif_resp_ready = 0; #2;
    check("host_resp_done", 32'(htif_resp_valid), 32'h0);

    // System write stalls the host port
    csr(3'd5, 12'h325, 32'h0); htif_req_valid = 1; htif_req_addr = 12'hB04; #2;
    check("host_stall_ready", 32'(htif_req_ready), 32'h0);
    step();
    csr(3'd0, 12'h0, 0); htif_req_valid = 0; #2;
    check("host_stall_noresp", 32'(htif_resp_valid), 32'h0);

    // Host write ignores read-only shadow
    htif_req_valid = 1; htif_req_rw = 1; htif_req_addr = 12'hC05; htif_req_data = 32'h55; step();
    htif_req_valid = 0; htif_req_rw = 0; htif_resp_ready = 1; step();
    htif_resp_ready = 0; csr(3'd4, 12'hB05, 0); #2;
    check("host_write_shadow", rdata, 32'h55);

    // Reset mid-transaction
    csr(3'd0, 12'h0, 0);
    htif_req_valid = 1; htif_req_addr = 12'hB04; step();
    htif_req_valid = 0; #2;
    check("pre_reset_valid", 32'(htif_resp_valid), 32'h1);
    reset = 1; step();
    reset = 0; csr(3'd4, 12'hB04, 0); #2;
    check("post_reset_valid", 32'(htif_resp_valid), 32'h0);
    check("post_reset_ready", 32'(htif_req_ready), 32'h1);
    check("post_reset_cnt", rdata, 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      events          = 8'($urandom);
      cmd             = cmds[$urandom_range(0, 4)];
      addr            = alist[$urandom_range(0, 19)];
      wdata           = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      prv             = 2'($urandom_range(0, 3));
      htif_req_valid  = ($urandom_range(0, 2) == 0);
      htif_req_rw     = 1'($urandom);
      htif_req_addr   = alist[$urandom_range(0, 19)];
      htif_req_data   = $urandom;
      htif_resp_ready = 1'($urandom);
      #2;
      check_all();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
